// File: rtl/lift_car_ctrl.sv
// Lift car motion controller.
// Uses the slow tick level from the divider as a time base (one step per
// rising edge), latches floor calls, moves the car one floor per
// TRAVEL_TICKS steps and holds the door open for DOOR_TICKS steps.
// Optional feature: define LIFT_OBSTRUCT_EN to let door_obstruct hold the
// door open; without it door_obstruct is ignored.
module lift_car_ctrl #(
    parameter int N_FLOORS     = 8,
    parameter int FLOOR_W      = 3,
    parameter int TRAVEL_TICKS = 3,
    parameter int DOOR_TICKS   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [N_FLOORS-1:0] call_req,
    input  logic                door_obstruct,
    output logic [FLOOR_W-1:0]  floor,
    output logic                dir_up,
    output logic                moving,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pending
);

    localparam int TRV_W  = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
    localparam int DOOR_W = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DOOR_OPEN = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic                  dir_q, dir_d;
    logic [N_FLOORS-1:0]   pending_q, pending_d;
    logic [TRV_W-1:0]      trv_q, trv_d;
    logic [DOOR_W-1:0]     door_q, door_d;
    logic                  tick_dly_q, tick_dly_d;
    logic                  step;
    logic                  obstruct_hold;
    logic [FLOOR_W-1:0]    nxt_floor;

`ifdef LIFT_OBSTRUCT_EN
    assign obstruct_hold = door_obstruct;
`else
    // Obstruction sensing not built: the door closes purely on its timer.
    logic unused_obstruct;
    assign unused_obstruct = door_obstruct;
    assign obstruct_hold   = 1'b0;
`endif

    // One-hot mask selecting floor f.
    function automatic logic [N_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
        logic [N_FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            m[i] = (FLOOR_W'(i) == f);
        end
        return m;
    endfunction

    // Any outstanding call strictly above floor f.
    function automatic logic any_above(input logic [N_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0]  f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if ((FLOOR_W'(i) > f) && p[i]) r = 1'b1;
        end
        return r;
    endfunction

    // Any outstanding call strictly below floor f.
    function automatic logic any_below(input logic [N_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0]  f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if ((FLOOR_W'(i) < f) && p[i]) r = 1'b1;
        end
        return r;
    endfunction

    assign step = tick & ~tick_dly_q;

    // Next-state logic: call latching, direction choice, travel and door timers.
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        trv_d      = '0;
        door_d     = '0;
        tick_dly_d = tick;
        nxt_floor  = floor_q;
        pending_d  = pending_q | call_req;

        case (state_q)
            S_IDLE: begin
                if ((pending_q & floor_mask(floor_q)) != '0) begin
                    state_d   = S_DOOR_OPEN;
                    pending_d = pending_d & ~floor_mask(floor_q);
                end else if (any_above(pending_q, floor_q) &&
                             (dir_q || !any_below(pending_q, floor_q))) begin
                    state_d = S_MOVE_UP;
                    dir_d   = 1'b1;
                end else if (any_below(pending_q, floor_q)) begin
                    state_d = S_MOVE_DOWN;
                    dir_d   = 1'b0;
                end
            end

            S_MOVE_UP, S_MOVE_DOWN: begin
                trv_d = trv_q;
                if (step) begin
                    if (trv_q == TRV_W'(TRAVEL_TICKS - 1)) begin
                        trv_d     = '0;
                        nxt_floor = (state_q == S_MOVE_UP) ? floor_q + FLOOR_W'(1)
                                                           : floor_q - FLOOR_W'(1);
                        floor_d   = nxt_floor;
                        if ((pending_q & floor_mask(nxt_floor)) != '0) begin
                            state_d   = S_DOOR_OPEN;
                            pending_d = pending_d & ~floor_mask(nxt_floor);
                        end else if (state_q == S_MOVE_UP ? !any_above(pending_q, nxt_floor)
                                                          : !any_below(pending_q, nxt_floor)) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        trv_d = trv_q + TRV_W'(1);
                    end
                end
            end

            S_DOOR_OPEN: begin
                door_d = door_q;
                if ((call_req & floor_mask(floor_q)) != '0) begin
                    // A repeat call at this floor keeps the door open longer
                    // instead of queueing a second visit.
                    pending_d = pending_d & ~floor_mask(floor_q);
                    door_d    = '0;
                end else if (obstruct_hold) begin
                    door_d = '0;
                end else if (step) begin
                    if (door_q == DOOR_W'(DOOR_TICKS - 1)) begin
                        state_d = S_IDLE;
                        door_d  = '0;
                    end else begin
                        door_d = door_q + DOOR_W'(1);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset returns the car to floor 0 at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            floor_q    <= '0;
            dir_q      <= 1'b1;
            pending_q  <= '0;
            trv_q      <= '0;
            door_q     <= '0;
            tick_dly_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            dir_q      <= dir_d;
            pending_q  <= pending_d;
            trv_q      <= trv_d;
            door_q     <= door_d;
            tick_dly_q <= tick_dly_d;
        end
    end

    assign floor     = floor_q;
    assign dir_up    = dir_q;
    assign moving    = (state_q == S_MOVE_UP) || (state_q == S_MOVE_DOWN);
    assign door_open = (state_q == S_DOOR_OPEN);
    assign pending   = pending_q;

endmodule

// File: tb/tb_lift_car_ctrl.sv
// Self-checking bench for lift_car_ctrl: table vectors, directed sequences
// and random stimulus against a behavioural model of the lift.
module tb_lift_car_ctrl;

    localparam int NF = 8;
    localparam int FW = 3;
    localparam int TT = 3;
    localparam int DT = 4;

`ifdef LIFT_OBSTRUCT_EN
    localparam bit OBS = 1'b1;
`else
    localparam bit OBS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic [NF-1:0] call_req;
    logic          door_obstruct;
    logic [FW-1:0] floor;
    logic          dir_up;
    logic          moving;
    logic          door_open;
    logic [NF-1:0] pending;

    always #5 clk = ~clk;

    lift_car_ctrl #(
        .N_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .call_req(call_req),
        .door_obstruct(door_obstruct), .floor(floor), .dir_up(dir_up),
        .moving(moving), .door_open(door_open), .pending(pending)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 waiting, 1 going up, 2 going down, 3 door open
    int m_mode;
    int m_floor;
    bit m_dir;
    bit m_pend[NF];
    int m_trav;
    int m_door;
    bit m_tprev;

    function automatic int cnt(input bit p[NF], input int lo, input int hi);
        int n;
        n = 0;
        for (int i = 0; i < NF; i++) if (i >= lo && i <= hi && p[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_floor = 0; m_dir = 1'b1; m_trav = 0; m_door = 0; m_tprev = 1'b0;
        for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
    endtask

    task automatic model_clock();
        bit step;
        bit old[NF];
        int up_n, dn_n;
        step    = tick && !m_tprev;
        m_tprev = tick;
        old     = m_pend;
        for (int i = 0; i < NF; i++) if (call_req[i]) m_pend[i] = 1'b1;
        case (m_mode)
            0: begin
                if (old[m_floor]) begin
                    m_mode = 3; m_door = 0; m_pend[m_floor] = 1'b0;
                end else begin
                    up_n = cnt(old, m_floor + 1, NF - 1);
                    dn_n = cnt(old, 0, m_floor - 1);
                    if (up_n > 0 && (m_dir || dn_n == 0)) begin
                        m_mode = 1; m_dir = 1'b1;
                    end else if (dn_n > 0) begin
                        m_mode = 2; m_dir = 1'b0;
                    end
                end
            end
            1, 2: begin
                if (step) begin
                    m_trav++;
                    if (m_trav == TT) begin
                        m_trav  = 0;
                        m_floor = m_floor + ((m_mode == 1) ? 1 : -1);
                        if (old[m_floor]) begin
                            m_mode = 3; m_door = 0; m_pend[m_floor] = 1'b0;
                        end else if ((m_mode == 1) ? (cnt(old, m_floor + 1, NF - 1) == 0)
                                                   : (cnt(old, 0, m_floor - 1) == 0)) begin
                            m_mode = 0;
                        end
                    end
                end
            end
            default: begin
                if (call_req[m_floor]) begin
                    m_pend[m_floor] = 1'b0; m_door = 0;
                end else if (OBS && door_obstruct) begin
                    m_door = 0;
                end else if (step) begin
                    m_door++;
                    if (m_door == DT) begin
                        m_door = 0; m_mode = 0;
                    end
                end
            end
        endcase
    endtask

    function automatic logic [31:0] model_vec();
        logic [NF-1:0] pk;
        for (int i = 0; i < NF; i++) pk[i] = m_pend[i];
        return 32'({FW'(m_floor), m_dir, (m_mode == 1 || m_mode == 2), (m_mode == 3), pk});
    endfunction

    // One clock: advance the model with the inputs the DUT sees, then compare.
    task automatic cyc();
        @(posedge clk);
        if (reset) model_clock();
        else model_reset();
        #1;
        check("model", 32'({floor, dir_up, moving, door_open, pending}), model_vec());
    endtask

    task automatic tick_step();
        tick = 1'b1; cyc();
        tick = 1'b0; cyc();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        cyc(); cyc();
        reset = 1'b1;
    endtask

    typedef struct {
        logic          tick;
        logic [NF-1:0] call;
        logic [FW-1:0] e_floor;
        logic          e_mov;
        logic          e_door;
        logic [NF-1:0] e_pend;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(input logic t, input logic [NF-1:0] c,
                                input logic d, input logic [NF-1:0] p);
        vec_t v;
        v.tick = t; v.call = c; v.e_floor = '0; v.e_mov = 1'b0; v.e_door = d; v.e_pend = p;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   steps;
        bit   done;
        bit   bstep;
        bit   prev_t;
        int   phase;
        int   door_floors[$];
        bit   prev_door;
        bit   saw_down;
        int   f0, f1;

        // Door-at-current-floor sequence, including a repeat call that
        // restarts the door timer.
        tbl[0]  = mk(1'b0, 8'h01, 1'b0, 8'h01);
        tbl[1]  = mk(1'b0, 8'h00, 1'b1, 8'h00);
        tbl[2]  = mk(1'b1, 8'h00, 1'b1, 8'h00);
        tbl[3]  = mk(1'b0, 8'h00, 1'b1, 8'h00);
        tbl[4]  = mk(1'b1, 8'h00, 1'b1, 8'h00);
        tbl[5]  = mk(1'b0, 8'h01, 1'b1, 8'h00);
        tbl[6]  = mk(1'b1, 8'h00, 1'b1, 8'h00);
        tbl[7]  = mk(1'b0, 8'h00, 1'b1, 8'h00);
        tbl[8]  = mk(1'b1, 8'h00, 1'b1, 8'h00);
        tbl[9]  = mk(1'b0, 8'h00, 1'b1, 8'h00);
        tbl[10] = mk(1'b1, 8'h00, 1'b1, 8'h00);
        tbl[11] = mk(1'b0, 8'h00, 1'b1, 8'h00);
        tbl[12] = mk(1'b1, 8'h00, 1'b0, 8'h00);
        tbl[13] = mk(1'b1, 8'h00, 1'b0, 8'h00);

        tick = 1'b0; call_req = '0; door_obstruct = 1'b0;
        do_reset();
        check("rst_floor", 32'(floor), 32'(0));
        check("rst_dir", 32'(dir_up), 32'(1));
        check("rst_moving", 32'(moving), 32'(0));
        check("rst_door", 32'(door_open), 32'(0));
        check("rst_pending", 32'(pending), 32'(0));

        for (int i = 0; i < 14; i++) begin
            tick = tbl[i].tick; call_req = tbl[i].call;
            cyc();
            check($sformatf("tbl%0d", i), 32'({floor, moving, door_open, pending}),
                  32'({tbl[i].e_floor, tbl[i].e_mov, tbl[i].e_door, tbl[i].e_pend}));
        end
        call_req = '0;

        // A: call floor 3 from floor 0 with a 10-clock tick period.
        tick = 1'b0; cyc(); cyc();
        call_req = 8'h08; cyc();
        check("a_latch", 32'({moving, pending}), 32'({1'b0, 8'h08}));
        call_req = 8'h00; cyc();
        check("a_start", 32'({moving, dir_up}), 32'({1'b1, 1'b1}));
        steps = 0; done = 1'b0; prev_t = 1'b0; phase = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            phase++;
            tick   = ((phase % 10) >= 5);
            bstep  = tick && !prev_t;
            prev_t = tick;
            cyc();
            if (bstep) begin
                steps++;
                if (steps <= 9) check($sformatf("a_floor_s%0d", steps), 32'(floor), 32'(steps / 3));
                if (steps == 8) check("a_pend_before", 32'({door_open, pending}), 32'({1'b0, 8'h08}));
                if (steps == 9) check("a_arrive", 32'({door_open, pending}), 32'({1'b1, 8'h00}));
                if (steps == 12) check("a_door_held", 32'(door_open), 32'(1));
                if (steps == 13) begin
                    check("a_door_closed", 32'(door_open), 32'(0));
                    done = 1'b1;
                end
            end
        end
        check("a_budget", 32'(steps), 32'(13));

        // C: at floor 3 with calls 5 and 1: serve 5 first, then come down to 1.
        tick = 1'b0; cyc();
        call_req = 8'h22; cyc();
        call_req = 8'h00; cyc();
        check("c_start", 32'({moving, dir_up, floor}), 32'({1'b1, 1'b1, 3'd3}));
        prev_door = 1'b0; saw_down = 1'b0; done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            tick_step();
            if (door_open && !prev_door) door_floors.push_back(int'(floor));
            prev_door = door_open;
            if (moving && !dir_up) saw_down = 1'b1;
            if (door_floors.size() == 2 && !door_open && !moving) done = 1'b1;
        end
        f0 = (door_floors.size() > 0) ? door_floors[0] : -1;
        f1 = (door_floors.size() > 1) ? door_floors[1] : -1;
        check("c_stops", 32'(door_floors.size()), 32'(2));
        check("c_first", 32'(f0), 32'(5));
        check("c_second", 32'(f1), 32'(1));
        check("c_down", 32'(saw_down), 32'(1));
        check("c_end", 32'({floor, pending}), 32'({3'd1, 8'h00}));

        // D: door obstruction at floor 1.
        call_req = 8'h02; cyc();
        call_req = 8'h00; cyc();
        check("d_open", 32'(door_open), 32'(1));
        door_obstruct = 1'b1;
`ifdef LIFT_OBSTRUCT_EN
        for (int k = 0; k < 10; k++) begin
            tick_step();
            check($sformatf("d_hold%0d", k), 32'(door_open), 32'(1));
        end
        door_obstruct = 1'b0;
`endif
        repeat (3) tick_step();
        check("d_before_close", 32'(door_open), 32'(1));
        tick_step();
        check("d_closed", 32'(door_open), 32'(0));
        door_obstruct = 1'b0;

        // E: tick held high advances the travel counter by one step only.
        cyc();
        call_req = 8'h10; cyc();
        call_req = 8'h00; cyc();
        check("e_start", 32'({moving, dir_up}), 32'({1'b1, 1'b1}));
        tick = 1'b1;
        repeat (50) cyc();
        tick = 1'b0;
        repeat (3) cyc();
        check("e_hold", 32'(floor), 32'(1));
        tick_step();
        check("e_step2", 32'(floor), 32'(1));
        tick_step();
        check("e_step3", 32'(floor), 32'(2));
        repeat (12) tick_step();
        check("e_end", 32'({floor, moving, door_open, pending}), 32'({3'd4, 1'b0, 1'b0, 8'h00}));

        // B: asynchronous reset while moving up at floor 2.
        do_reset();
        call_req = 8'h20; cyc();
        call_req = 8'h00; cyc();
        for (int k = 0; k < 20 && floor != 3'd2; k++) tick_step();
        check("b_reach", 32'({moving, dir_up, floor}), 32'({1'b1, 1'b1, 3'd2}));
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check("b_floor", 32'(floor), 32'(0));
        check("b_moving", 32'(moving), 32'(0));
        check("b_pending", 32'(pending), 32'(0));
        check("b_dir", 32'(dir_up), 32'(1));
        check("b_door", 32'(door_open), 32'(0));
        cyc(); cyc();
        reset = 1'b1;

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            call_req = ($urandom_range(0, 11) == 0) ? (NF'(1) << $urandom_range(0, NF - 1)) : '0;
            if ($urandom_range(0, 2) == 0) tick = ~tick;
            if ($urandom_range(0, 24) == 0) door_obstruct = ~door_obstruct;
            if (k == 1500) begin
                reset = 1'b0;
                model_reset();
            end else begin
                reset = 1'b1;
            end
            cyc();
        end
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
